ethpipe_rx_ring: RTL and testbench
==================================

# ethpipe_rx_ring

Parametrised GMII receive engine that strips preamble/SFD, packs received bytes into `DATA_BYTES`-wide memory words, and writes each frame into one of `SLOT_NUM` ring slots. It is the multi-slot successor of the single-slot RX path and sits between the GMII RX pins and the slot RAM read by the PCI side. Per-frame metadata is delivered on a one-cycle descriptor strobe, and slot recycling is handled by a release handshake. Clock-domain crossing of `slot_release` and the descriptor is done outside this block.

## Interface
- `DATA_BYTES`, 4: memory word width in bytes; legal values 1, 2, 4, 8.
- `SLOT_NUM`, 4: ring slot count; power of two, at least 2.
- `SLOT_ADDR_W`, 9: word-address width inside a slot. Constraint: `DATA_BYTES*2**SLOT_ADDR_W` ≤ 2048.
- `gmii_rx_clk`  in  1  sole clock; all logic is on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `global_counter`  in  64  free-running timestamp source.
- `gmii_rxd`  in  8  GMII receive data.
- `gmii_rx_dv`  in  1  GMII data valid.
- `gmii_rx_er`  in  1  GMII receive error.
- `mem_data`  out  8*DATA_BYTES  write data; lane k is `[8k+7:8k]`.
- `mem_byte_en`  out  DATA_BYTES  per-lane write enable.
- `mem_addr`  out  log2(SLOT_NUM)+SLOT_ADDR_W  address, formed as {slot, word index}.
- `mem_wr_en`  out  1  write strobe.
- `slot_release`  in  1  one-cycle pulse; frees the oldest filled slot.
- `desc_valid`  out  1  one-cycle frame-complete strobe.
- `desc_slot`  out  log2(SLOT_NUM)  slot that holds the frame.
- `desc_len`  out  12  byte count after the SFD, including FCS.
- `desc_timestamp`  out  64  `global_counter` sampled on the SFD cycle.
- `desc_err`  out  1  set for `rx_er`, runt (<64 bytes) or oversize frames.
- `slots_used`  out  log2(SLOT_NUM)+1  number of filled, unreleased slots.
- `drop_count`  out  16  frames dropped because the ring was full; saturates at 16'hFFFF.

## Operation
- Reset value of every output is 0; the write slot pointer and read slot pointer also reset to 0.
- State machine:
  - **WAIT_IDLE**: entered on reset. Moves to IDLE when a cycle with `dv`=0 is sampled.
  - **IDLE**: on `dv`=1, goes to DROP if `slots_used`==SLOT_NUM and increments `drop_count`; otherwise goes to PREAMBLE.
  - **PREAMBLE**: on `dv`=1 with `rxd`==8'hD5, captures the timestamp and goes to DATA. On `dv`=0, returns to IDLE with no descriptor and no slot consumed.
  - **DATA**: packs bytes. On `dv`=0, goes to FLUSH.
  - **FLUSH**: goes to DONE.
  - **DONE**: emits the descriptor, then returns to IDLE.
  - **DROP**: discards bytes until `dv`=0, then returns to IDLE. No memory writes occur in DROP.
- Packing:
  - Byte n (0-based after the SFD) goes to lane n mod DATA_BYTES of word n/DATA_BYTES in the current write slot.
  - A full word is written with all byte enables set.
  - At FLUSH, a partial word is written with only its filled lanes enabled; unused lanes carry zero data. No FLUSH write occurs if the last word was already full.
- Oversize: once `DATA_BYTES*2**SLOT_ADDR_W` bytes have been stored, further bytes are discarded, `desc_len` saturates at that value, and `desc_err` is set. There is never a write outside the slot.
- Error flags: `gmii_rx_er` high in any DATA cycle sets `desc_err`. So does a final length below 64.
- DONE actions: the write slot pointer advances modulo SLOT_NUM and `slots_used` increments.
- Release: `slot_release` decrements `slots_used`. A release while `slots_used`==0 is ignored.
- Release and DONE in the same cycle leave `slots_used` unchanged.

## Timing
- `mem_*` outputs are registered. A full word's write is presented for one cycle, starting at the edge that samples its last byte.
- Let E0 be the edge that samples `dv`=0 after DATA.
  - A partial-word write, if any, is presented from E0.
  - `desc_valid` and the descriptor fields are valid for exactly one cycle from E1.
  - `slots_used` updates at E1.
- The descriptor path's worst case is 2 cycles. The standard 12-byte IPG guarantees IDLE is reached before the next frame starts.
- `drop_count` and the full decision are taken on the edge that samples the rising `dv` in IDLE.
- Reset mid-frame forces all outputs to 0 immediately. The rest of the frame is ignored via WAIT_IDLE.

## Test plan
- **64-byte frame:** 7×8'h55 + 8'hD5 preamble, then 64 bytes, with DATA_BYTES=4. Required: 16 writes to addresses 0..15 with `byte_en`=4'hF; `desc_slot`=0, `desc_len`=64, `desc_err`=0; `desc_timestamp` equals the counter value on the SFD cycle; `slots_used`=1.
- **65-byte frame:** Required: 17th write at slot word 16 with `byte_en`=4'b0001 and data {24'h0, byte64}; `desc_len`=65.
- **Ring full and wrap:** SLOT_NUM=4, five frames with no release. Required: fifth frame produces no writes and no descriptor; `drop_count`=1; `slots_used`=4. Then one release followed by a frame: the frame lands in slot 0 and `slots_used` returns to 4.
- **Error frames:**
  - `rx_er` for one cycle inside a 100-byte frame → `desc_err`=1.
  - A 40-byte frame → `desc_err`=1, `desc_len`=40.
  - Preamble with `dv` dropping before the SFD → no descriptor.
- **Oversize:** a 2100-byte frame with defaults. Required: exactly 512 writes, `desc_len`=2048, `desc_err`=1.
- **Reset and same-cycle events:**
  - `sys_rst_n` low mid-frame → all outputs 0, and nothing is written until `dv` has been low and a new frame arrives.
  - `slot_release` coinciding with `desc_valid` → `slots_used` unchanged.

Source files
------------

// File: rtl/ethpipe_rx_ring.sv
// ethpipe_rx_ring
// GMII receive engine that strips preamble/SFD, packs received bytes into
// DATA_BYTES-wide memory words and writes each frame into one of SLOT_NUM
// ring slots. A one-cycle descriptor strobe reports each completed frame;
// slots are recycled by a release pulse from the consumer.
//
// Ports
//   gmii_rx_clk      sole clock, rising edge
//   sys_rst_n        asynchronous active-low reset
//   global_counter   free-running timestamp, sampled on the SFD cycle
//   gmii_rxd/dv/er   GMII receive pins
//   mem_data         write data, lane k = [8k+7:8k]
//   mem_byte_en      per-lane write enable
//   mem_addr         {slot, word index}
//   mem_wr_en        write strobe (one cycle per word)
//   slot_release     one-cycle pulse, frees the oldest filled slot
//   desc_valid       one-cycle frame-complete strobe
//   desc_slot/len/timestamp/err   frame metadata, valid with desc_valid
//   slots_used       filled, unreleased slot count
//   drop_count       frames dropped on a full ring, saturating
module ethpipe_rx_ring #(
  parameter int DATA_BYTES  = 4,
  parameter int SLOT_NUM    = 4,
  parameter int SLOT_ADDR_W = 9
) (
  input  logic                                    gmii_rx_clk,
  input  logic                                    sys_rst_n,
  input  logic [63:0]                             global_counter,
  input  logic [7:0]                              gmii_rxd,
  input  logic                                    gmii_rx_dv,
  input  logic                                    gmii_rx_er,
  output logic [8*DATA_BYTES-1:0]                 mem_data,
  output logic [DATA_BYTES-1:0]                   mem_byte_en,
  output logic [$clog2(SLOT_NUM)+SLOT_ADDR_W-1:0] mem_addr,
  output logic                                    mem_wr_en,
  input  logic                                    slot_release,
  output logic                                    desc_valid,
  output logic [$clog2(SLOT_NUM)-1:0]             desc_slot,
  output logic [11:0]                             desc_len,
  output logic [63:0]                             desc_timestamp,
  output logic                                    desc_err,
  output logic [$clog2(SLOT_NUM):0]               slots_used,
  output logic [15:0]                             drop_count
);

  localparam int SLOT_W = $clog2(SLOT_NUM);
  localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int ADDR_W = SLOT_W + SLOT_ADDR_W;
  // Bytes a single slot can hold; also the saturation value of desc_len.
  localparam logic [11:0]       CAP_BYTES  = 12'(DATA_BYTES * (2 ** SLOT_ADDR_W));
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(DATA_BYTES - 1);
  localparam logic [SLOT_W:0]   FULL_SLOTS = (SLOT_W + 1)'(SLOT_NUM);
  localparam logic [11:0]       MIN_LEN    = 12'd64;

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_PREAMBLE  = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_DROP      = 3'd6;

  logic [2:0]               state_q, state_d;
  logic [SLOT_W-1:0]        wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]        rd_slot_q, rd_slot_d;
  logic [SLOT_W:0]          slots_used_q, slots_used_d;
  logic [15:0]              drop_count_q, drop_count_d;
  logic [11:0]              byte_cnt_q, byte_cnt_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [SLOT_ADDR_W-1:0]   word_q, word_d;
  logic [8*DATA_BYTES-1:0]  buf_q, buf_d;
  logic [63:0]              ts_q, ts_d;
  logic                     er_seen_q, er_seen_d;
  logic                     ovf_q, ovf_d;

  logic [8*DATA_BYTES-1:0]  mem_data_q, mem_data_d;
  logic [DATA_BYTES-1:0]    mem_byte_en_q, mem_byte_en_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic                     mem_wr_en_q, mem_wr_en_d;
  logic                     desc_valid_q, desc_valid_d;
  logic [SLOT_W-1:0]        desc_slot_q, desc_slot_d;
  logic [11:0]              desc_len_q, desc_len_d;
  logic [63:0]              desc_ts_q, desc_ts_d;
  logic                     desc_err_q, desc_err_d;

  logic [8*DATA_BYTES-1:0]  merged;
  logic [DATA_BYTES-1:0]    partial_be;
  logic                     slot_inc;
  logic                     slot_dec;

  // merged: the word buffer with the incoming byte dropped into its lane.
  // partial_be: lanes already filled in the buffer (used by the flush write).
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
    assign merged[8*gi +: 8] = (lane_q == LANE_W'(gi)) ? gmii_rxd : buf_q[8*gi +: 8];
    assign partial_be[gi]    = (LANE_W'(gi) < lane_q);
  end

  always_comb begin
    state_d       = state_q;
    wr_slot_d     = wr_slot_q;
    rd_slot_d     = rd_slot_q;
    slots_used_d  = slots_used_q;
    drop_count_d  = drop_count_q;
    byte_cnt_d    = byte_cnt_q;
    lane_d        = lane_q;
    word_d        = word_q;
    buf_d         = buf_q;
    ts_d          = ts_q;
    er_seen_d     = er_seen_q;
    ovf_d         = ovf_q;
    mem_data_d    = mem_data_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = 1'b0;
    desc_valid_d  = 1'b0;
    desc_slot_d   = desc_slot_q;
    desc_len_d    = desc_len_q;
    desc_ts_d     = desc_ts_q;
    desc_err_d    = desc_err_q;
    slot_inc      = 1'b0;
    // A release with nothing filled has nothing to free.
    slot_dec      = slot_release && (slots_used_q != '0);

    case (state_q)
      S_WAIT_IDLE: begin
        // Ignore the tail of any frame that was in flight at reset.
        if (!gmii_rx_dv) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (slots_used_q == FULL_SLOTS) begin
            state_d = S_DROP;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
          end else begin
            state_d = S_PREAMBLE;
          end
        end
      end
      S_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end else if (gmii_rxd == 8'hD5) begin
          state_d    = S_DATA;
          ts_d       = global_counter;
          byte_cnt_d = '0;
          lane_d     = '0;
          word_d     = '0;
          buf_d      = '0;
          er_seen_d  = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      S_DATA: begin
        if (gmii_rx_er) er_seen_d = 1'b1;
        if (gmii_rx_dv) begin
          if (byte_cnt_q < CAP_BYTES) begin
            byte_cnt_d = byte_cnt_q + 12'd1;
            if (lane_q == LAST_LANE) begin
              mem_wr_en_d   = 1'b1;
              mem_data_d    = merged;
              mem_byte_en_d = '1;
              mem_addr_d    = {wr_slot_q, word_q};
              // Cleared so a later partial word carries zeros in unused lanes.
              buf_d         = '0;
              lane_d        = '0;
              word_d        = word_q + 1'b1;
            end else begin
              buf_d  = merged;
              lane_d = lane_q + 1'b1;
            end
          end else begin
            // Slot full: discard and flag, never address past the slot.
            ovf_d = 1'b1;
          end
        end else begin
          state_d = S_FLUSH;
          if (lane_q != '0) begin
            mem_wr_en_d   = 1'b1;
            mem_data_d    = buf_q;
            mem_byte_en_d = partial_be;
            mem_addr_d    = {wr_slot_q, word_q};
          end
        end
      end
      S_FLUSH: begin
        state_d      = S_DONE;
        desc_valid_d = 1'b1;
        desc_slot_d  = wr_slot_q;
        desc_len_d   = byte_cnt_q;
        desc_ts_d    = ts_q;
        desc_err_d   = er_seen_q | ovf_q | (byte_cnt_q < MIN_LEN);
        wr_slot_d    = wr_slot_q + 1'b1;
        slot_inc     = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DROP: begin
        if (!gmii_rx_dv) state_d = S_IDLE;
      end
      default: begin
        state_d = S_WAIT_IDLE;
      end
    endcase

    // Simultaneous fill and release cancel out.
    if (slot_inc && !slot_dec) begin
      slots_used_d = slots_used_q + 1'b1;
    end else if (slot_dec && !slot_inc) begin
      slots_used_d = slots_used_q - 1'b1;
    end
    if (slot_dec) rd_slot_d = rd_slot_q + 1'b1;
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_WAIT_IDLE;
      wr_slot_q     <= '0;
      rd_slot_q     <= '0;
      slots_used_q  <= '0;
      drop_count_q  <= '0;
      byte_cnt_q    <= '0;
      lane_q        <= '0;
      word_q        <= '0;
      buf_q         <= '0;
      ts_q          <= '0;
      er_seen_q     <= 1'b0;
      ovf_q         <= 1'b0;
      mem_data_q    <= '0;
      mem_byte_en_q <= '0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      desc_valid_q  <= 1'b0;
      desc_slot_q   <= '0;
      desc_len_q    <= '0;
      desc_ts_q     <= '0;
      desc_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_slot_q     <= wr_slot_d;
      rd_slot_q     <= rd_slot_d;
      slots_used_q  <= slots_used_d;
      drop_count_q  <= drop_count_d;
      byte_cnt_q    <= byte_cnt_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      buf_q         <= buf_d;
      ts_q          <= ts_d;
      er_seen_q     <= er_seen_d;
      ovf_q         <= ovf_d;
      mem_data_q    <= mem_data_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      desc_valid_q  <= desc_valid_d;
      desc_slot_q   <= desc_slot_d;
      desc_len_q    <= desc_len_d;
      desc_ts_q     <= desc_ts_d;
      desc_err_q    <= desc_err_d;
    end
  end

  assign mem_data       = mem_data_q;
  assign mem_byte_en    = mem_byte_en_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wr_en      = mem_wr_en_q;
  assign desc_valid     = desc_valid_q;
  assign desc_slot      = desc_slot_q;
  assign desc_len       = desc_len_q;
  assign desc_timestamp = desc_ts_q;
  assign desc_err       = desc_err_q;
  assign slots_used     = slots_used_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_ethpipe_rx_ring.sv
// Scoreboard bench for ethpipe_rx_ring with default parameters
// (DATA_BYTES=4, SLOT_NUM=4, SLOT_ADDR_W=9). The stimulus thread pushes
// expected writes and descriptors; a monitor pops and compares them.
module tb_ethpipe_rx_ring;

  localparam int DB  = 4;
  localparam int SN  = 4;
  localparam int SAW = 9;
  localparam int CAP = DB * (2 ** SAW);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] gc = 64'h1000;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        rel = 1'b0;

  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [10:0] mem_addr;
  logic        mem_wr;
  logic        dvld;
  logic [1:0]  dslot;
  logic [11:0] dlen;
  logic [63:0] dts;
  logic        derr;
  logic [2:0]  used;
  logic [15:0] drops;

  ethpipe_rx_ring #(.DATA_BYTES(DB), .SLOT_NUM(SN), .SLOT_ADDR_W(SAW)) dut (
    .gmii_rx_clk(clk), .sys_rst_n(rst_n), .global_counter(gc),
    .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .mem_data(mem_data), .mem_byte_en(mem_be), .mem_addr(mem_addr), .mem_wr_en(mem_wr),
    .slot_release(rel), .desc_valid(dvld), .desc_slot(dslot), .desc_len(dlen),
    .desc_timestamp(dts), .desc_err(derr), .slots_used(used), .drop_count(drops)
  );

  always #5 clk = ~clk;

  typedef struct { logic [10:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  typedef struct { logic [1:0] slot; logic [11:0] len; logic [63:0] ts; logic err; } desc_t;

  wr_t   wq[$];
  desc_t dq[$];
  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int desc_seen = 0;

  // Reference model state (stimulus thread only).
  logic [1:0]  m_wr = 2'd0;
  int          m_used = 0;
  int          m_drop = 0;
  logic [31:0] acc;
  int          lane;
  int          word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented write/descriptor against the scoreboard.
  initial begin
    wr_t   ew;
    desc_t ed;
    forever begin
      @(negedge clk);
      if (mem_wr) begin
        wr_seen++;
        $display("wr   addr=%03h data=%08h be=%h", mem_addr, mem_data, mem_be);
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", mem_addr, mem_data);
        end else begin
          ew = wq.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(ew.addr));
          check("wr_data", 64'(mem_data), 64'(ew.data));
          check("wr_be",   64'(mem_be),   64'(ew.be));
        end
      end
      if (dvld) begin
        desc_seen++;
        $display("desc slot=%0d len=%0d ts=%0h err=%0d", dslot, dlen, dts, derr);
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_desc: got slot=%0d len=%0d, required no descriptor", dslot, dlen);
        end else begin
          ed = dq.pop_front();
          check("desc_slot", 64'(dslot), 64'(ed.slot));
          check("desc_len",  64'(dlen),  64'(ed.len));
          check("desc_ts",   dts,        ed.ts);
          check("desc_err",  64'(derr),  64'(ed.err));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    gc = gc + 64'h1_0000_0003;
  endtask

  task automatic push_wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_t w;
    w.addr = a; w.data = d; w.be = b;
    wq.push_back(w);
  endtask

  task automatic check_zero(input string tag);
    $display("reset check %s", tag);
    check("rst_mem_wr",   64'(mem_wr),   64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_be",   64'(mem_be),   64'd0);
    check("rst_desc_vld", 64'(dvld),     64'd0);
    check("rst_desc_len", 64'(dlen),     64'd0);
    check("rst_desc_ts",  dts,           64'd0);
    check("rst_desc_err", 64'(derr),     64'd0);
    check("rst_used",     64'(used),     64'd0);
    check("rst_drops",    64'(drops),    64'd0);
  endtask

  task automatic send_pre(output logic [63:0] ts);
    for (int i = 0; i < 7; i++) begin
      tick(); dv = 1'b1; rxd = 8'h55; er = 1'b0;
    end
    tick(); rxd = 8'hD5; ts = gc;
  endtask

  task automatic send_body(input int nb, input int seed, input int er_pos, input bit push);
    acc = '0; lane = 0; word = 0;
    for (int n = 0; n < nb; n++) begin
      tick();
      rxd = 8'(seed + n * 7);
      er  = (n == er_pos);
      if (push && n < CAP) begin
        acc[8*lane +: 8] = rxd;
        if (lane == DB - 1) begin
          push_wr({m_wr, 9'(word)}, acc, 4'hF);
          acc = '0; lane = 0; word++;
        end else begin
          lane++;
        end
      end
    end
  endtask

  task automatic frame(input int nb, input int seed, input int er_pos, input bit rel_at_done);
    logic [63:0] ts;
    desc_t d;
    bit push;
    int len;
    push = (m_used < SN);
    len  = (nb > CAP) ? CAP : nb;
    $display("frame bytes=%0d slot=%0d stored=%0d", nb, m_wr, push);
    send_pre(ts);
    send_body(nb, seed, er_pos, push);
    tick(); dv = 1'b0; er = 1'b0; rxd = 8'h00;
    if (push) begin
      if (lane != 0) push_wr({m_wr, 9'(word)}, acc, 4'((1 << lane) - 1));
      d.slot = m_wr;
      d.len  = 12'(len);
      d.ts   = ts;
      d.err  = (er_pos >= 0 && er_pos < nb) || (nb > CAP) || (len < 64);
      dq.push_back(d);
    end else if (m_drop < 65535) begin
      m_drop++;
    end
    tick(); rel = rel_at_done;   // sampled on the descriptor edge
    tick(); rel = 1'b0;
    if (push) begin
      m_wr = m_wr + 2'd1;
      if (!rel_at_done) m_used++;
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic release_slot();
    tick(); rel = 1'b1;
    tick(); rel = 1'b0;
    if (m_used > 0) m_used--;
    $display("release used=%0d", m_used);
  endtask

  initial begin
    int w0;
    int d0;
    logic [63:0] ts;

    // Reset state
    tick(); tick();
    check_zero("power-on");
    tick(); rst_n = 1'b1;
    tick(); tick();

    // 64-byte frame -> slot 0, 16 full words
    frame(64, 8'h10, -1, 1'b0);
    check("used_after_64", 64'(used), 64'(m_used));
    // 65-byte frame -> slot 1, trailing single-lane write
    frame(65, 8'h21, -1, 1'b0);
    check("used_after_65", 64'(used), 64'(m_used));
    // Runt
    frame(40, 8'h33, -1, 1'b0);
    // rx_er inside 100-byte frame
    frame(100, 8'h47, 50, 1'b0);
    check("used_full", 64'(used), 64'd4);

    // Ring full: dropped, no writes, no descriptor
    w0 = wr_seen; d0 = desc_seen;
    frame(64, 8'h59, -1, 1'b0);
    check("drop_no_wr",   64'(wr_seen),   64'(w0));
    check("drop_no_desc", 64'(desc_seen), 64'(d0));
    check("drop_count",   64'(drops),     64'(m_drop));
    check("used_on_drop", 64'(used),      64'd4);

    // Release then a frame that wraps to slot 0
    release_slot();
    check("used_after_rel", 64'(used), 64'(m_used));
    frame(64, 8'h6A, -1, 1'b0);
    check("used_refill", 64'(used), 64'd4);

    // Preamble abort
    release_slot();
    release_slot();
    d0 = desc_seen;
    for (int i = 0; i < 4; i++) begin tick(); dv = 1'b1; rxd = 8'h55; end
    tick(); dv = 1'b0; rxd = 8'h00;
    for (int i = 0; i < 12; i++) tick();
    $display("preamble abort");
    check("abort_no_desc", 64'(desc_seen), 64'(d0));
    check("abort_used",    64'(used),      64'(m_used));

    // Release coinciding with the descriptor strobe
    frame(70, 8'h7B, -1, 1'b1);
    check("used_rel_same", 64'(used), 64'(m_used));

    // Oversize: 512 full writes, saturated length
    w0 = wr_seen;
    frame(2100, 8'h8C, -1, 1'b0);
    check("oversize_writes", 64'(wr_seen - w0), 64'd512);
    check("used_after_big",  64'(used), 64'(m_used));

    // Reset mid-frame: 5 words written, then the remainder is ignored
    send_pre(ts);
    send_body(21, 8'h9D, -1, 1'b1);
    tick(); rxd = 8'hD5;
    #2 rst_n = 1'b0;
    #1 check_zero("mid-frame");
    m_wr = 2'd0; m_used = 0; m_drop = 0;
    w0 = wr_seen; d0 = desc_seen;
    tick(); rxd = 8'h55;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); rxd = (i == 3) ? 8'hD5 : 8'(i); end
    tick(); dv = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("rst_tail_no_wr",   64'(wr_seen),   64'(w0));
    check("rst_tail_no_desc", 64'(desc_seen), 64'(d0));
    frame(64, 8'hAE, -1, 1'b0);
    check("used_post_rst", 64'(used), 64'd1);

    for (int i = 0; i < 5; i++) tick();
    check("wq_drained", 64'(wq.size()), 64'd0);
    check("dq_drained", 64'(dq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
